// File: rtl/cpu_axi_master.sv
// Single-beat AXI4 master bridging a simple core req/done port onto AR/R/AW/W/B.
// One transaction in flight; done/err/rdata are registered and presented the cycle after the response.
module cpu_axi_master #(
   parameter logic [3:0] MASTER_ID = 4'd0
) (
   input  logic        clk,
   input  logic        rst,
   // core side
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        ready,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   // read address
   output logic [3:0]  ARID,
   output logic [31:0] ARADDR,
   output logic [3:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARVALID,
   input  logic        ARREADY,
   // read data
   input  logic [3:0]  RID,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY,
   // write address
   output logic [3:0]  AWID,
   output logic [31:0] AWADDR,
   output logic [3:0]  AWLEN,
   output logic [2:0]  AWSIZE,
   output logic [1:0]  AWBURST,
   output logic        AWVALID,
   input  logic        AWREADY,
   // write data
   output logic [31:0] WDATA,
   output logic [3:0]  WSTRB,
   output logic        WLAST,
   output logic        WVALID,
   input  logic        WREADY,
   // write response
   input  logic [3:0]  BID,
   input  logic [1:0]  BRESP,
   input  logic        BVALID,
   output logic        BREADY
);

   typedef enum logic [2:0] {ST_IDLE, ST_RADDR, ST_RDATA, ST_WREQ, ST_WRESP} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic        unused_rlast;

   // Single beat: RLAST carries no information.
   assign unused_rlast = RLAST;

   // All channel outputs come straight from flops, never from READY.
   assign ARID    = MASTER_ID;
   assign ARADDR  = addr_q;
   assign ARLEN   = 4'd0;
   assign ARSIZE  = 3'b010;
   assign ARBURST = 2'b01;
   assign ARVALID = (state_q == ST_RADDR);
   assign RREADY  = (state_q == ST_RDATA);

   assign AWID    = MASTER_ID;
   assign AWADDR  = addr_q;
   assign AWLEN   = 4'd0;
   assign AWSIZE  = 3'b010;
   assign AWBURST = 2'b01;
   assign AWVALID = (state_q == ST_WREQ) && !aw_done_q;
   assign WDATA   = wdata_q;
   assign WSTRB   = wstrb_q;
   assign WLAST   = 1'b1;
   assign WVALID  = (state_q == ST_WREQ) && !w_done_q;
   assign BREADY  = (state_q == ST_WRESP);

   // The done cycle is spent in IDLE with ready held low, forcing one idle gap.
   assign ready = (state_q == ST_IDLE) && !done_q;
   assign done  = done_q;
   assign err   = err_q;
   assign rdata = rdata_q;

   assign ar_hs = ARVALID && ARREADY;
   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign r_hs  = RREADY && RVALID && (RID == MASTER_ID);
   assign b_hs  = BREADY && BVALID && (BID == MASTER_ID);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req && ready) begin
               addr_d  = addr;
               wdata_d = wdata;
               wstrb_d = wstrb;
               state_d = we ? ST_WREQ : ST_RADDR;
            end
         end
         ST_RADDR: begin
            if (ar_hs) state_d = ST_RDATA;
         end
         ST_RDATA: begin
            if (r_hs) begin
               rdata_d = RDATA;
               err_d   = RRESP[1];
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_WREQ: begin
            // AW and W complete independently; leave once both are through.
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_WRESP;
            end else begin
               aw_done_d = aw_done_q || aw_hs;
               w_done_d  = w_done_q || w_hs;
            end
         end
         ST_WRESP: begin
            if (b_hs) begin
               err_d   = BRESP[1];
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         rdata_q   <= 32'h0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: doc/cpu_axi_master.md
CPU_AXI_MASTER -- requirements
Module: cpu_axi_master

Interface
REQ-001 Parameter MASTER_ID, default 4'd0: value driven on ARID and AWID, 4 bits.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  core request strobe; sampled only while ready=1.
REQ-005 we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 addr  input  32  byte address of the request.
REQ-007 wdata  input  32  write data.
REQ-008 wstrb  input  4  write byte strobes.
REQ-009 ready  output  1  SHALL be 1 only in IDLE; the core may present req only then.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rdata  output  32  read data; valid in the done cycle of a read and held until the next read completes.
REQ-012 err  output  1  1 in the done cycle if the response was SLVERR or DECERR (RESP[1]=1), else 0.
REQ-013 ARID 4, ARADDR 32, ARLEN 4, ARSIZE 3, ARBURST 2, ARVALID 1  outputs  AXI read-address channel.
REQ-014 ARREADY  input  1  read-address handshake.
REQ-015 RID 4, RDATA 32, RRESP 2, RLAST 1, RVALID 1  inputs; RREADY  output  1  AXI read-data channel.
REQ-016 AWID 4, AWADDR 32, AWLEN 4, AWSIZE 3, AWBURST 2, AWVALID 1  outputs  AXI write-address channel.
REQ-017 AWREADY  input  1  write-address handshake.
REQ-018 WDATA 32, WSTRB 4, WLAST 1, WVALID 1  outputs; WREADY  input  1  AXI write-data channel.
REQ-019 BID 4, BRESP 2, BVALID 1  inputs; BREADY  output  1  AXI write-response channel.

Function
REQ-020 All transactions SHALL be single-beat: ARLEN=AWLEN=4'd0, ARSIZE=AWSIZE=3'b010, ARBURST=AWBURST=2'b01 (INCR), WLAST=1 whenever WVALID=1.
REQ-021 FSM states SHALL be IDLE, RADDR, RDATA, WREQ, WRESP.
REQ-022 IDLE with req=1: latch addr/wdata/wstrb in the same edge; we=0 -> RADDR, we=1 -> WREQ; the next cycle drives the latched values.
REQ-023 RADDR: ARVALID=1 with ARADDR = latched addr; on ARVALID&ARREADY -> RDATA.
REQ-024 RDATA: RREADY=1; on RVALID&RREADY, capture RDATA into rdata, set err=RRESP[1], pulse done, -> IDLE.
REQ-025 WREQ: AWVALID and WVALID SHALL both assert on state entry; each deasserts after its own handshake (aw_done/w_done flags); the handshakes may complete in either order or in the same cycle.
REQ-026 WREQ -> WRESP on the cycle in which both handshakes are complete (flags or current handshakes); flags clear on exit.
REQ-027 WRESP: BREADY=1; on BVALID&BREADY, set err=BRESP[1], pulse done, -> IDLE; rdata unchanged.
REQ-028 Once asserted, a VALID SHALL stay high and its payload SHALL stay stable until the handshake completes (AXI rule); VALID SHALL NOT depend combinationally on READY.
REQ-029 RREADY/BREADY SHALL be 1 only in RDATA/WRESP; RVALID/BVALID seen in other states SHALL be ignored.
REQ-030 Mismatching RID/BID SHALL be ignored; RLAST is not checked (single beat).
REQ-031 done SHALL be 0 except for the single completion cycle; ready SHALL be 0 in that cycle and 1 the following cycle, so back-to-back requests cost at least one IDLE cycle.
REQ-032 A DECERR response (e.g. from the default slave) SHALL complete normally with err=1, never hang.

Reset
REQ-033 While rst=0: state=IDLE, ARVALID=AWVALID=WVALID=RREADY=BREADY=0, done=0, err=0, rdata=32'h0, aw_done=w_done=0, ready=1; rst asserted mid-transaction SHALL abort it immediately with no done pulse.

Verification
REQ-034 Read 0x0000_0100, slave ARREADY after 2 cycles, RDATA=32'hDEAD_BEEF, RRESP=00 -> ARVALID held 2 cycles stable, done pulse, rdata=DEADBEEF, err=0.
REQ-035 Write 0x0001_0000, wdata=32'h1234_5678, wstrb=4'b0011, WREADY before AWREADY -> WVALID drops first, AWVALID held, BREADY then done, err=0, ARLEN/AWLEN=0, WLAST=1.
REQ-036 Write with AWREADY and WREADY in the same cycle as entry -> WRESP next cycle; BRESP=2'b11 -> done with err=1.
REQ-037 Read to an unmapped address, RRESP=2'b11, RDATA=0 -> done, err=1, rdata=0, FSM returns to IDLE, ready=1 next cycle.
REQ-038 rst pulsed low while in RDATA waiting for RVALID -> all VALID/READY outputs 0 same cycle, no done, next read completes normally.
